// File: rtl/smg_scan_if.sv
// Segment-code / display bus between the segment encoder and the scan driver.
// master: encoder side (drives codes); slave: scan driver side (drives the display).
interface smg_scan_if;
  logic [7:0] ten_encode;
  logic [7:0] one_encode;
  logic [7:0] smg_data;
  logic [1:0] smg_scan;

  modport master (
    output ten_encode,
    output one_encode,
    input  smg_data,
    input  smg_scan
  );

  modport slave (
    input  ten_encode,
    input  one_encode,
    output smg_data,
    output smg_scan
  );
endinterface

// File: rtl/smg_scan_mod.sv
// Two-digit common-anode 7-seg scan driver with per-slot blanking and code latching.
// Optional leading-zero suppression of the ten digit: define SMG_ZERO_BLANK_EN.
module smg_scan_mod #(
  parameter int unsigned SCAN_T  = 20000,
  parameter int unsigned BLANK_T = 200
) (
  input logic       CLK,
  input logic       RST_n,
  smg_scan_if.slave bus
);

  if (SCAN_T < 2 || SCAN_T > 65535 || BLANK_T < 1 || BLANK_T >= SCAN_T) begin : g_param_check
    $error("smg_scan_mod: illegal SCAN_T/BLANK_T combination");
  end

  typedef enum logic [1:0] {
    S_BLANK_TEN,
    S_SHOW_TEN,
    S_BLANK_ONE,
    S_SHOW_ONE
  } state_t;

  localparam logic [15:0] CNT_LAST  = 16'(SCAN_T - 1);
  localparam logic [15:0] BLANK_END = 16'(BLANK_T);
  localparam logic [7:0]  SEG_OFF   = 8'hFF;
  localparam logic [1:0]  SEL_NONE  = 2'b11;
  localparam logic [1:0]  SEL_TEN   = 2'b01;
  localparam logic [1:0]  SEL_ONE   = 2'b10;

  state_t      state;
  logic [15:0] cnt;
  logic        ptr_ten;
  logic [7:0]  ten_hold;
  logic [7:0]  one_hold;

  // Display word {smg_data, smg_scan} for a ten-digit code.
  function automatic logic [9:0] ten_word(input logic [7:0] code);
`ifdef SMG_ZERO_BLANK_EN
    if (code == 8'hC0) return {SEG_OFF, SEL_NONE};
`endif
    return {code, SEL_TEN};
  endfunction

  function automatic logic [9:0] one_word(input logic [7:0] code);
    return {code, SEL_ONE};
  endfunction

  // cnt holds the number of edges already taken in the current slot, so the
  // state change decided at cnt==BLANK_T lands on relative edge BLANK_T+1 and
  // the change decided at cnt==0 lands on the first edge of the next slot.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state        <= S_BLANK_TEN;
      cnt          <= '0;
      ptr_ten      <= 1'b1;
      ten_hold     <= '1;
      one_hold     <= '1;
      bus.smg_data <= '1;
      bus.smg_scan <= '1;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt     <= '0;
        ptr_ten <= ~ptr_ten;
      end else begin
        cnt <= cnt + 16'd1;
      end

      case (state)
        S_BLANK_TEN: begin
          if (cnt == BLANK_END) begin
            state                        <= S_SHOW_TEN;
            ten_hold                     <= bus.ten_encode;
            {bus.smg_data, bus.smg_scan} <= ten_word(bus.ten_encode);
          end else begin
            {bus.smg_data, bus.smg_scan} <= {SEG_OFF, SEL_NONE};
          end
        end

        S_BLANK_ONE: begin
          if (cnt == BLANK_END) begin
            state                        <= S_SHOW_ONE;
            one_hold                     <= bus.one_encode;
            {bus.smg_data, bus.smg_scan} <= one_word(bus.one_encode);
          end else begin
            {bus.smg_data, bus.smg_scan} <= {SEG_OFF, SEL_NONE};
          end
        end

        S_SHOW_TEN: begin
          if (cnt == '0) begin
            state                        <= ptr_ten ? S_BLANK_TEN : S_BLANK_ONE;
            {bus.smg_data, bus.smg_scan} <= {SEG_OFF, SEL_NONE};
          end else begin
            {bus.smg_data, bus.smg_scan} <= ten_word(ten_hold);
          end
        end

        S_SHOW_ONE: begin
          if (cnt == '0) begin
            state                        <= ptr_ten ? S_BLANK_TEN : S_BLANK_ONE;
            {bus.smg_data, bus.smg_scan} <= {SEG_OFF, SEL_NONE};
          end else begin
            {bus.smg_data, bus.smg_scan} <= one_word(one_hold);
          end
        end

        default: begin
          state                        <= S_BLANK_TEN;
          {bus.smg_data, bus.smg_scan} <= {SEG_OFF, SEL_NONE};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smg_scan_mod.sv
// Scoreboard bench for smg_scan_mod: nominal instance (10/2) and boundary instance (10/9).
module tb_smg_scan_mod;

  logic CLK = 1'b0;
  logic RST_n;

  always #5 CLK = ~CLK;

  smg_scan_if if_a ();
  smg_scan_if if_b ();

  smg_scan_mod #(.SCAN_T(10), .BLANK_T(2)) dut_a (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (if_a.slave)
  );

  smg_scan_mod #(.SCAN_T(10), .BLANK_T(9)) dut_b (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (if_b.slave)
  );

  typedef struct {
    int unsigned dut;
    int unsigned edge_no;
    logic [9:0]  exp;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned e        = 0;
  logic [7:0]  cur_ten, cur_one;
  logic [7:0]  m_ten[2];
  logic [7:0]  m_one[2];

  task automatic set_codes(input logic [7:0] t, input logic [7:0] o);
    cur_ten = t;
    cur_one = o;
    if_a.ten_encode = t;
    if_a.one_encode = o;
    if_b.ten_encode = t;
    if_b.one_encode = o;
  endtask

  // Expected outputs of instance d right after edge e, from slot arithmetic.
  task automatic model(input int unsigned d, output logic [9:0] w);
    int unsigned s, b, rel, slot;
    s    = 10;
    b    = (d == 0) ? 2 : 9;
    rel  = ((e - 1) % s) + 1;
    slot = (e - 1) / s;
    if (rel <= b) begin
      w = {8'hFF, 2'b11};
    end else if (slot % 2 == 0) begin
      if (rel == b + 1) m_ten[d] = cur_ten;
      w = {m_ten[d], 2'b01};
`ifdef SMG_ZERO_BLANK_EN
      if (m_ten[d] == 8'hC0) w = {8'hFF, 2'b11};
`endif
    end else begin
      if (rel == b + 1) m_one[d] = cur_one;
      w = {m_one[d], 2'b10};
    end
  endtask

  task automatic push(input int unsigned d, input logic [9:0] w);
    sb_t s;
    s.dut     = d;
    s.edge_no = e;
    s.exp     = w;
    sb_q.push_back(s);
  endtask

  task automatic check_pop();
    sb_t        s;
    logic [9:0] obs;
    while (sb_q.size() > 0) begin
      s   = sb_q.pop_front();
      obs = (s.dut == 0) ? {if_a.smg_data, if_a.smg_scan} : {if_b.smg_data, if_b.smg_scan};
      n_assert++;
      assert (obs === s.exp) else begin
        n_fail++;
        $error("FAIL dut%0d edge=%0d {data,scan} got %h_%b want %h_%b",
               s.dut, s.edge_no, obs[9:2], obs[1:0], s.exp[9:2], s.exp[1:0]);
      end
    end
  endtask

  task automatic check_blank();
    push(0, {8'hFF, 2'b11});
    push(1, {8'hFF, 2'b11});
    check_pop();
  endtask

  task automatic step();
    logic [9:0] w;
    e++;
    for (int unsigned d = 0; d < 2; d++) begin
      model(d, w);
      push(d, w);
    end
    @(posedge CLK);
    #1;
    check_pop();
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST_n = 1'b1;
    e     = 0;
    for (int unsigned d = 0; d < 2; d++) begin
      m_ten[d] = 8'hFF;
      m_one[d] = 8'hFF;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_n = 1'b0;
    #1;
    check_blank();
    release_reset();
  endtask

  initial begin
    RST_n = 1'b0;
    set_codes(8'hF9, 8'hA4);
    #12;
    check_blank();

    // First frame, then a ten-code change inside the first show window.
    release_reset();
    repeat (5) step();
    set_codes(8'hA4, 8'hA4);
    repeat (20) step();

    // Asynchronous reset between edges 15 and 16, then restart at slot 0.
    set_codes(8'hF9, 8'hA4);
    do_reset();
    repeat (15) step();
    #2;
    RST_n = 1'b0;
    #1;
    check_blank();
    release_reset();
    repeat (20) step();

    // Leading zero on the ten digit.
    set_codes(8'hC0, 8'hA4);
    do_reset();
    repeat (20) step();

    // 1000 slots with codes changing at arbitrary points.
    do_reset();
    for (int unsigned i = 0; i < 10000; i++) begin
      if (i % 7 == 0) set_codes(8'($urandom), 8'($urandom));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/smg_scan_mod.md
# smg_scan_mod

Time-multiplexed scan driver for the two-digit common-anode seven-segment display. It consumes the per-digit 8-bit segment codes produced by the segment encoder (ten and one digit, active-low segments, bit 7 = dp). It drives them onto the single shared segment bus while alternately enabling one digit-select line. A blanking interval precedes every digit slot to suppress ghosting, and codes are latched once per slot so the display never shows a torn value.

## Interface

Parameters:
- SCAN_T, 20000, clock cycles per digit slot (1 ms at 20 MHz); 2 ≤ SCAN_T ≤ 65535
- BLANK_T, 200, leading blank cycles within each slot; 1 ≤ BLANK_T < SCAN_T

Ports:
- CLK  input  1  system clock; the only clock
- RST_n  input  1  asynchronous, active-low reset
- ten_encode  input  8  ten-digit segment code, active-low (8'hC0 = '0', 8'hFF = blank)
- one_encode  input  8  one-digit segment code, same format
- smg_data  output  8  shared segment bus, active-low, registered
- smg_scan  output  2  digit select, active-low, registered; bit 1 = ten digit, bit 0 = one digit

## Operation

- 16-bit slot counter `cnt`: counts 0..SCAN_T-1, wraps to 0, and toggles the digit pointer (TEN→ONE→TEN…) on wrap.
- FSM states: S_BLANK_TEN, S_SHOW_TEN, S_BLANK_ONE, S_SHOW_ONE.
  - BLANK→SHOW of the same digit after BLANK_T cycles.
  - SHOW→BLANK of the other digit when `cnt` wraps.
- BLANK states: smg_data = 8'hFF, smg_scan = 2'b11.
- Entering a SHOW state:
  - Sample the corresponding input code into a hold register.
  - Hold the value for the whole show window; input changes mid-window are ignored until that digit's next slot.
- S_SHOW_TEN: smg_scan = 2'b01, smg_data = held ten code.
- S_SHOW_ONE: smg_scan = 2'b10, smg_data = held one code.
- Invariant: smg_scan is never 2'b00. No combinational path exists from the inputs to the outputs.
- Input codes are passed through unmodified, including non-digit patterns such as 8'hFF.

## Timing

- Reset (asserted, asynchronous, without a clock): smg_data = 8'hFF, smg_scan = 2'b11, state = S_BLANK_TEN, `cnt` = 0, hold registers = 8'hFF.
- Edge numbering: the first rising CLK edge with RST_n high is edge 1.
- Slot k occupies edges k·SCAN_T+1 .. (k+1)·SCAN_T. Even k = ten digit, odd k = one digit.
- Within a slot:
  - Edges 1..BLANK_T (relative to slot start) produce blank outputs.
  - Edges BLANK_T+1..SCAN_T produce show outputs.
  - The input code is sampled at relative edge BLANK_T+1.
- Each show window lasts exactly SCAN_T−BLANK_T cycles. Each blank gap lasts exactly BLANK_T cycles.
- Reset mid-operation: outputs return to blank immediately. After release, operation restarts at slot 0 (ten digit).
- Full scan period is 2·SCAN_T cycles, with no drift across counter wraps.

## Configuration

- Macro: SMG_ZERO_BLANK_EN.
- Defined: if the sampled ten code equals 8'hC0, the ten show window outputs smg_scan = 2'b11 and smg_data = 8'hFF (leading-zero suppression). Slot timing and one-digit behaviour are unchanged.
- Undefined: 8'hC0 is displayed like any other code.

## Test plan

All scenarios use SCAN_T=10, BLANK_T=2 unless stated.

- Reset and first frame: hold RST_n low → 8'hFF/2'b11. Release with ten=8'hF9, one=8'hA4 → edges 1–2 blank; edges 3–10 scan=2'b01, data=8'hF9; edges 11–12 blank; edges 13–20 scan=2'b10, data=8'hA4.
- Mid-window change: ten 8'hF9→8'hA4 just after edge 5 → data stays 8'hF9 through edge 10; 8'hA4 first appears at edge 23.
- Async reset mid-show: drop RST_n between edges 15 and 16 → outputs become 8'hFF/2'b11 before edge 16. After release, edges 1–2 blank and edges 3–10 show ten.
- Leading zero: ten=8'hC0, one=8'hA4.
  - Macro defined: edges 3–10 give 8'hFF/2'b11; edges 13–20 give 8'hA4/2'b10.
  - Macro undefined: edges 3–10 give 8'hC0/2'b01.
- Boundary BLANK_T=9, SCAN_T=10, run 1000 slots: exactly one show cycle per slot, strict ten/one alternation, smg_scan never 2'b00, blank gap always 9 cycles.
